// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths and constants for the fetch stage with prefetch queue.
package inst_fetch_queue_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int FETCH_STEP  = 4;

    // Bits needed to hold any value in 0..max_val inclusive.
    function automatic int count_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Synchronous FIFO holding {pc, inst} fetch entries; clear beats push/pop.
module fetch_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int WIDTH = INST_ADDR_W + INST_W,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    input  logic                          clear,
    output logic [WIDTH-1:0]              head,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = storage[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            storage[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: in-order requests to variable-latency instruction memory, a prefetch
// queue of {pc, inst} toward decode, and flush redirect that drops stale responses.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int                ADDR_W    = INST_ADDR_W,
    parameter int                DATA_W    = INST_W,
    parameter int                DEPTH     = 4,
    parameter int                MAX_OUTST = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    output logic              if_valid_o,
    input  logic              if_ready_i,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [DATA_W-1:0] if_inst_o
);

    localparam int CNT_W = count_width(DEPTH);
    localparam int OW    = count_width(MAX_OUTST);
    localparam int OCC_W = count_width(DEPTH + MAX_OUTST);

    logic [ADDR_W-1:0]        fetch_pc;
    logic [ADDR_W-1:0]        resp_pc;
    logic [OW-1:0]            outst;
    logic [OW-1:0]            discard;
    logic                     fetch_en;
    logic [ADDR_W-1:0]        flush_target;
    logic [OCC_W-1:0]         occupancy;
    logic                     accept;
    logic                     resp;
    logic                     push;
    logic                     pop;
    logic [ADDR_W+DATA_W-1:0] fifo_head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CNT_W-1:0]         fifo_count;
    logic [ADDR_W-1:0]        head_pc;
    logic [DATA_W-1:0]        head_inst;

    assign flush_target = {flush_pc_i[ADDR_W-1:2], 2'b00};

    // Requests still owed to the queue count against its space; discarded ones do not.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(outst) - OCC_W'(discard);
    assign mem_req_o = fetch_en && !flush_i && (outst < OW'(MAX_OUTST))
                       && (occupancy < OCC_W'(DEPTH));
    assign mem_addr_o = fetch_pc;

    assign accept = mem_req_o && mem_ready_i;
    assign resp   = mem_rvalid_i && (outst != '0);
    assign push   = resp && !flush_i && (discard == '0);
    assign pop    = if_valid_o && if_ready_i && !flush_i;

    fetch_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({resp_pc, mem_rdata_i}),
        .pop       (pop),
        .clear     (flush_i),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign {head_pc, head_inst} = fifo_head;
    assign if_valid_o = !fifo_empty;
    assign if_pc_o    = fifo_empty ? '0 : head_pc;
    assign if_inst_o  = fifo_empty ? '0 : head_inst;

    // On flush every request still in flight after this edge becomes stale: outst minus
    // the response consumed this cycle, whether or not it was already marked for discard.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            outst    <= '0;
            discard  <= '0;
            fetch_en <= 1'b0;
        end else begin
            fetch_en <= 1'b1;
            outst    <= outst + OW'(accept) - OW'(resp);
            if (flush_i) begin
                fetch_pc <= flush_target;
                resp_pc  <= flush_target;
                discard  <= outst - OW'(resp);
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + ADDR_W'(FETCH_STEP);
                end
                if (push) begin
                    resp_pc <= resp_pc + ADDR_W'(FETCH_STEP);
                end
                if (resp && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
            end
        end
    end

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst)
        !(mem_rvalid_i && (outst == '0)));

    a_discard_bounded: assert property (@(posedge clk) disable iff (!rst)
        discard <= outst);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && fifo_full && !pop));

    a_addr_held: assert property (@(posedge clk) disable iff (!rst)
        (mem_req_o && !mem_ready_i) |=> (mem_addr_o == $past(mem_addr_o)));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue with a variable-latency in-order memory model.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic        if_valid_o;
    logic        if_ready_i = 1'b0;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
    typedef struct { int due; logic [31:0] addr; } pend_t;

    exp_t  exp_q[$];
    pend_t pend_q[$];
    int    deliv_cyc[$];
    int    cyc = 0;
    int    lat = 1;
    int    check_count = 0;
    int    pass_count = 0;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .DEPTH     (4),
        .MAX_OUTST (2),
        .RESET_PC  (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ready_i  (mem_ready_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .if_valid_o   (if_valid_o),
        .if_ready_i   (if_ready_i),
        .if_pc_o      (if_pc_o),
        .if_inst_o    (if_inst_o)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic mem_ready, input logic if_ready,
                                 input logic flush, input logic [31:0] fpc);
        mem_ready_i = mem_ready;
        if_ready_i  = if_ready;
        flush_i     = flush;
        flush_pc_i  = fpc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_q.push_back('{pc, inst_of(pc)});
    endtask

    // Holds mem_ready high until exactly n requests have been accepted.
    task automatic issue(input int n);
        int acc = 0;
        int guard = 0;
        mem_ready_i = 1'b1;
        while (acc < n && guard < 200) begin
            @(negedge clk);
            if (mem_req_o) acc++;
            step();
            guard++;
        end
        mem_ready_i = 1'b0;
        checkOutput("issue_count", acc, n);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        checkOutput("drain_left", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) step();
    endtask

    // Memory model: sample handshakes at negedge, update and drive just after posedge.
    initial begin : mem_model
        logic        acc;
        logic        rsp;
        logic [31:0] addr;
        int          n;
        forever begin
            @(negedge clk);
            acc  = mem_req_o && mem_ready_i;
            rsp  = mem_rvalid_i;
            addr = mem_addr_o;
            @(posedge clk);
            cyc++;
            n = cyc;
            #1;
            if (!rst) begin
                pend_q.delete();
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = '0;
            end else begin
                if (rsp && pend_q.size() > 0) void'(pend_q.pop_front());
                if (acc) pend_q.push_back('{n + lat, addr});
                if (pend_q.size() > 0 && pend_q[0].due <= n + 1) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = inst_of(pend_q[0].addr);
                end else begin
                    mem_rvalid_i = 1'b0;
                    mem_rdata_i  = '0;
                end
            end
        end
    end

    // Monitor: every accepted head is compared against the next expected entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && if_valid_o && if_ready_i && !flush_i) begin
                deliv_cyc.push_back(cyc);
                check_count++;
                if (exp_q.size() == 0) begin
                    $display("[TB] FAIL sb_unexpected: got pc=0x%08h inst=0x%08h, required no output",
                             if_pc_o, if_inst_o);
                end else begin
                    e = exp_q.pop_front();
                    if (if_pc_o === e.pc && if_inst_o === e.inst) begin
                        pass_count++;
                    end else begin
                        $display("[TB] FAIL sb_entry: got pc=0x%08h inst=0x%08h, required pc=0x%08h inst=0x%08h",
                                 if_pc_o, if_inst_o, e.pc, e.inst);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        int span;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) step();
        @(negedge clk);
        checkOutput("rst_mem_req", mem_req_o, 0);
        checkOutput("rst_if_valid", if_valid_o, 0);
        checkOutput("rst_if_pc", if_pc_o, 0);
        checkOutput("rst_if_inst", if_inst_o, 0);
        step();
        rst = 1'b1;

        $display("[TB] streaming fetch, latency 1");
        lat = 1;
        if_ready_i = 1'b1;
        deliv_cyc.delete();
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
        issue(4);
        wait_drain(50);
        span = (deliv_cyc.size() >= 4) ? deliv_cyc[3] - deliv_cyc[0] : -1;
        checkOutput("one_per_cycle_span", span, 3);

        $display("[TB] decode stall fills queue");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (10) step();
        @(negedge clk);
        checkOutput("stall_mem_req", mem_req_o, 0);
        checkOutput("stall_if_valid", if_valid_o, 1);
        checkOutput("stall_head_pc", if_pc_o, 32'h10);
        checkOutput("stall_fetch_addr", mem_addr_o, 32'h20);
        step();
        expect_pc(32'h10); expect_pc(32'h14); expect_pc(32'h18); expect_pc(32'h1C);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        wait_drain(50);

        $display("[TB] memory backpressure, latency 3");
        lat = 3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("held_req", mem_req_o, 1);
            checkOutput("held_addr", mem_addr_o, 32'h20);
            step();
        end
        expect_pc(32'h20); expect_pc(32'h24); expect_pc(32'h28); expect_pc(32'h2C);
        issue(4);
        wait_drain(100);

        $display("[TB] flush with two requests in flight");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h10);
        step();
        flush_i = 1'b0;
        @(negedge clk);
        checkOutput("idle_flush_addr", mem_addr_o, 32'h10);
        step();
        issue(2);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h102);
        @(negedge clk);
        checkOutput("flush_no_req", mem_req_o, 0);
        step();
        flush_i = 1'b0;
        @(negedge clk);
        checkOutput("flush_target_addr", mem_addr_o, 32'h100);
        step();
        expect_pc(32'h100); expect_pc(32'h104);
        issue(2);
        wait_drain(100);

        $display("[TB] flush coinciding with response and pop");
        lat = 1;
        if_ready_i = 1'b0;
        issue(2);
        lat = 3;
        issue(1);
        step();
        step();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h200);
        @(negedge clk);
        checkOutput("pre_flush_valid", if_valid_o, 1);
        checkOutput("pre_flush_head", if_pc_o, 32'h108);
        step();
        flush_i = 1'b0;
        @(negedge clk);
        checkOutput("post_flush_valid", if_valid_o, 0);
        checkOutput("post_flush_pc", if_pc_o, 0);
        checkOutput("post_flush_inst", if_inst_o, 0);
        step();
        lat = 1;
        expect_pc(32'h200); expect_pc(32'h204);
        issue(2);
        wait_drain(50);

        $display("[TB] reset mid-burst");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) step();
        rst = 1'b0;
        #1;
        checkOutput("async_rst_valid", if_valid_o, 0);
        checkOutput("async_rst_req", mem_req_o, 0);
        checkOutput("async_rst_pc", if_pc_o, 0);
        checkOutput("async_rst_addr", mem_addr_o, 32'h0);
        mem_ready_i = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        if_ready_i = 1'b1;
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
        issue(3);
        wait_drain(50);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
